// File: rtl/mem_lsu.sv
// MEM-stage load/store unit and MEM/WB result latch; big-endian byte lanes, req/ack data bus.
// Non-memory ops retire in 1 cycle; memory ops stall the pipe until ack or timeout abort.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic        flush,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] bad_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [4:0]  lat_wd;
  logic        lat_wreg;
  logic [3:0]  lat_op;
  logic [31:0] lat_addr;
  logic        discard;

  logic        op_load, op_store, op_mem, aligned;
  logic [1:0]  op_size;
  logic        issue, mis_hit, timeout_hit;
  logic [3:0]  sel_nx;
  logic [31:0] wdata_nx;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Decode of the instruction currently sitting in EX/MEM
  always_comb begin
    op_load  = 1'b0;
    op_store = 1'b0;
    op_size  = SZ_W;
    case (mem_op)
      OP_LB, OP_LBU: begin op_load  = 1'b1; op_size = SZ_B; end
      OP_LH, OP_LHU: begin op_load  = 1'b1; op_size = SZ_H; end
      OP_LW:         begin op_load  = 1'b1; op_size = SZ_W; end
      OP_SB:         begin op_store = 1'b1; op_size = SZ_B; end
      OP_SH:         begin op_store = 1'b1; op_size = SZ_H; end
      OP_SW:         begin op_store = 1'b1; op_size = SZ_W; end
      default:       ;
    endcase
  end

  assign op_mem  = op_load | op_store;
  assign aligned = (op_size == SZ_B) ||
                   (op_size == SZ_H && !mem_addr[0]) ||
                   (op_size == SZ_W && mem_addr[1:0] == 2'b00);

  // A flushed instruction never reaches the bus and never reports misalignment
  assign issue       = (state == S_IDLE) && op_mem && aligned && !flush;
  assign mis_hit     = (state == S_IDLE) && op_mem && !aligned && !flush;
  assign timeout_hit = (state == S_WAIT) && !bus_ack && (cnt == TMO);

  assign stallreq = issue || ((state == S_WAIT) && !bus_ack && (cnt != TMO));

  // Byte enables and replicated store data; bit3 is the most significant lane
  always_comb begin
    sel_nx   = 4'b1111;
    wdata_nx = mem_sdata;
    case (op_size)
      SZ_B: begin
        sel_nx   = 4'b1000 >> mem_addr[1:0];
        wdata_nx = {4{mem_sdata[7:0]}};
      end
      SZ_H: begin
        sel_nx   = mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_nx = {2{mem_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = bus_rdata[31:24];
    case (lat_addr[1:0])
      2'd1:    load_byte = bus_rdata[23:16];
      2'd2:    load_byte = bus_rdata[15:8];
      2'd3:    load_byte = bus_rdata[7:0];
      default: ;
    endcase
    load_half = lat_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (lat_op)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'h0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'h0, load_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (issue) state_nx = S_WAIT;
      S_WAIT:  if (bus_ack || timeout_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'h0;
      lat_wd    <= 5'h0;
      lat_wreg  <= 1'b0;
      lat_op    <= 4'h0;
      lat_addr  <= 32'h0;
      discard   <= 1'b0;
      wb_wd     <= 5'h0;
      wb_wreg   <= 1'b0;
      wb_wdata  <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bad_addr  <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_sel   <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (state == S_IDLE) begin
        if (issue) begin
          bus_req   <= 1'b1;
          bus_we    <= op_store;
          bus_addr  <= {mem_addr[31:2], 2'b00};
          bus_sel   <= sel_nx;
          bus_wdata <= wdata_nx;
          wb_wreg   <= 1'b0;
          lat_wd    <= mem_wd;
          lat_wreg  <= mem_wreg;
          lat_op    <= mem_op;
          lat_addr  <= mem_addr;
          discard   <= 1'b0;
          cnt       <= 8'h0;
        end else if (mis_hit) begin
          misalign <= 1'b1;
          bad_addr <= mem_addr;
          wb_wd    <= mem_wd;
          wb_wdata <= mem_wdata;
          wb_wreg  <= 1'b0;
        end else begin
          wb_wd    <= mem_wd;
          wb_wdata <= mem_wdata;
          wb_wreg  <= mem_wreg && !flush;
        end
      end else begin
        if (flush) discard <= 1'b1;
        if (bus_ack) begin
          bus_req <= 1'b0;
          wb_wd   <= lat_wd;
          // A flush arriving together with the ack still kills the writeback
          if (lat_op <= OP_LW) begin
            wb_wreg  <= lat_wreg && !discard && !flush;
            wb_wdata <= load_data;
          end else begin
            wb_wreg <= 1'b0;
          end
        end else if (timeout_hit) begin
          bus_req  <= 1'b0;
          bus_err  <= 1'b1;
          bad_addr <= lat_addr;
          wb_wreg  <= 1'b0;
        end else begin
          cnt     <= cnt + 8'h1;
          wb_wreg <= 1'b0;
        end
      end
    end
  end

endmodule
